// File: rtl/i2s_output_stage.sv
// I2S transmitter for a mono sample stream. Each sample is captured into a one-deep
// buffer, duplicated to left and right, and shifted out MSB first with the standard
// one-bclk data delay behind lrclk. All outputs come straight from flops.
module i2s_output_stage #(
  parameter int unsigned data_width = 16,
  parameter int unsigned clk_div    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [data_width-1:0] i_data,
  input  logic                         i_data_valid,
  output logic                         o_read_done,
  output logic                         o_bclk,
  output logic                         o_lrclk,
  output logic                         o_sdata,
  output logic                         o_underrun
);

  localparam int unsigned FrameBits = 2 * data_width;
  localparam int unsigned CntW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (clk_div > 1) ? $clog2(clk_div) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(clk_div - 1);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);
  localparam logic [CntW-1:0] HalfBit = CntW'(data_width);

  typedef enum logic {StEmpty, StFull} buf_state_e;

  logic [DivW-1:0]       div_q, div_d;
  logic                  bclk_q, bclk_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic [FrameBits-1:0]  shift_q, shift_d;
  buf_state_e            buf_state_q, buf_state_d;
  logic [data_width-1:0] buf_q, buf_d;
  logic                  read_done_q, read_done_d;
  logic                  underrun_q, underrun_d;

  logic tick;
  logic fall;
  logic frame_start;

  // Event decode: divider terminal count, bclk falling edge, frame boundary.
  always_comb begin
    tick        = (div_q == DivLast);
    fall        = tick & bclk_q;
    frame_start = fall & (bit_cnt_q == LastBit);
  end

  // Bit-clock divider: bclk toggles every clk_div cycles.
  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    bclk_d = bclk_q ^ tick;
  end

  // Bit counter, word select and serializer all advance on the bclk falling edge.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    if (fall) begin
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= HalfBit);
      // The MSB leaving here at frame start is the previous frame's right-channel LSB,
      // which gives the one-bclk delay behind lrclk for free.
      sdata_d   = shift_q[FrameBits-1];
      if (frame_start) begin
        shift_d = (buf_state_q == StFull) ? {buf_q, buf_q} : '0;
      end else begin
        shift_d = {shift_q[FrameBits-2:0], 1'b0};
      end
    end
  end

  // Sample buffer: capture when empty, drain into the shifter at frame start.
  always_comb begin
    buf_state_d = buf_state_q;
    buf_d       = buf_q;
    read_done_d = 1'b0;
    underrun_d  = frame_start & (buf_state_q == StEmpty);
    unique case (buf_state_q)
      StEmpty: begin
        // No bypass: a capture coinciding with an underrun waits for the next frame.
        if (i_data_valid) begin
          buf_d       = i_data;
          buf_state_d = StFull;
          read_done_d = 1'b1;
        end
      end
      StFull: begin
        if (frame_start) begin
          buf_state_d = StEmpty;
        end
      end
      default: buf_state_d = StEmpty;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      shift_q     <= '0;
      buf_state_q <= StEmpty;
      buf_q       <= '0;
      read_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      shift_q     <= shift_d;
      buf_state_q <= buf_state_d;
      buf_q       <= buf_d;
      read_done_q <= read_done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_read_done = read_done_q;
  assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_output_stage.sv
// Scoreboard bench for i2s_output_stage. A frame-level reference model predicts
// read_done/underrun cycles and the 2*W-bit word of every frame; a monitor compares.
module tb_i2s_output_stage;

  localparam int W   = 16;
  localparam int DIV = 4;
  localparam int BP  = 2 * DIV;   // clk cycles per bclk period
  localparam int FB  = 2 * W;     // bclk periods per frame
  localparam int F   = BP * FB;   // clk cycles per frame

  logic                clk;
  logic                reset;
  logic signed [W-1:0] i_data;
  logic                i_data_valid;
  logic                o_read_done;
  logic                o_bclk;
  logic                o_lrclk;
  logic                o_sdata;
  logic                o_underrun;

  i2s_output_stage #(
    .data_width(W),
    .clk_div   (DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .o_read_done (o_read_done),
    .o_bclk      (o_bclk),
    .o_lrclk     (o_lrclk),
    .o_sdata     (o_sdata),
    .o_underrun  (o_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: n = clk edges since reset release.
  int          n = 0;
  bit          m_full = 0;
  logic [W-1:0] m_buf = '0;
  int          rd_q[$];
  int          ur_q[$];
  logic [FB-1:0] word_q[$];

  // Monitor state.
  logic [FB-1:0] asm_word = '0;
  logic [FB-1:0] got_word = '0;
  logic          sd_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, n);
    end
  endtask

  // Reference model: frame starts every F cycles; one-deep buffer, no bypass.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        n = 0;
        m_full = 0;
        rd_q.delete();
        ur_q.delete();
        word_q.delete();
        word_q.push_back('0);
      end else begin
        bit fs;
        bit cap;
        n++;
        fs  = (n % F) == 0;
        cap = !m_full && (i_data_valid === 1'b1);
        if (fs) begin
          if (m_full) begin
            word_q.push_back({m_buf, m_buf});
            m_full = 0;
          end else begin
            word_q.push_back('0);
            ur_q.push_back(n);
          end
        end
        if (cap) begin
          m_buf  = i_data;
          m_full = 1;
          rd_q.push_back(n);
        end
      end
    end
  end

  // Monitor: compares outputs after every edge, assembles serial words per frame.
  initial begin
    forever begin
      @(negedge clk);
      if (n == 0) begin
        chk("reset_outputs", 64'({o_bclk, o_lrclk, o_sdata, o_read_done, o_underrun}), 64'(0));
        asm_word = '0;
        sd_hold  = 1'b0;
      end else begin
        bit exp_bclk;
        bit exp_lr;
        bit exp_rd;
        bit exp_ur;
        exp_bclk = ((n / DIV) % 2) == 1;
        exp_lr   = ((n / BP) % FB) >= W;
        chk("bclk_lrclk", 64'({o_bclk, o_lrclk}), 64'({exp_bclk, exp_lr}));
        exp_rd = (rd_q.size() > 0) && (rd_q[0] == n);
        if (exp_rd) void'(rd_q.pop_front());
        chk("read_done", 64'(o_read_done), 64'(exp_rd));
        exp_ur = (ur_q.size() > 0) && (ur_q[0] == n);
        if (exp_ur) void'(ur_q.pop_front());
        chk("underrun", 64'(o_underrun), 64'(exp_ur));
        if ((n % BP) == 0) begin
          int b;
          b = (n / BP) % FB;
          if (b == 0) begin
            asm_word[0] = o_sdata;
            if (word_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_word: got %0h, expected none queued (cycle %0d)", asm_word, n);
            end else begin
              chk("frame_word", 64'(asm_word), 64'(word_q.pop_front()));
            end
            got_word = asm_word;
            asm_word = '0;
          end else begin
            asm_word[FB-b] = o_sdata;
          end
          sd_hold = o_sdata;
        end else begin
          chk("sdata_stable", 64'(o_sdata), 64'(sd_hold));
        end
      end
    end
  end

  // Upstream handshake: present d, hold valid until read_done is seen.
  task automatic send(input logic [W-1:0] d, input bit keep);
    i_data       = d;
    i_data_valid = 1'b1;
    for (int t = 0; t < 3 * F; t++) begin
      @(negedge clk);
      if (o_read_done) begin
        if (!keep) i_data_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rd_timeout: got no o_read_done in %0d cycles, expected one", 3 * F);
    i_data_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    for (int t = 0; t < 10 * F && n != target; t++) @(negedge clk);
    if (n != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle: got cycle %0d, expected %0d", n, target);
    end
  endtask

  logic [W-1:0] coin_d;
  logic [W-1:0] base;

  initial begin
    reset        = 1'b0;
    i_data_valid = 1'b1;
    i_data       = 16'h8001;
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // Sample offered through reset is captured on the first edge after release.
    send(16'h8001, 1'b0);
    chk("first_rd_cycle", 64'(n), 64'(1));
    wait_until(2 * F + 1);
    chk("mono_8001_frame", 64'(got_word), 64'({16'h8001, 16'h8001}));

    // Idle through frame 2, then raise valid exactly on the frame-3 start edge.
    wait_until(3 * F - 1);
    coin_d = W'($urandom);
    send(coin_d, 1'b0);
    chk("coincide_rd_cycle", 64'(n), 64'(3 * F));
    wait_until(5 * F + 1);
    chk("coincide_frame", 64'(got_word), 64'({coin_d, coin_d}));

    // Continuous valid with incrementing data.
    base = W'($urandom);
    for (int i = 0; i < 6; i++) send(base + W'(i), i < 5);

    // Random gaps and data.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2 * F)) @(negedge clk);
      send(W'($urandom), 1'b0);
    end

    // One-cycle reset at bit_cnt 20 with the buffer full.
    for (int t = 0; t < 2 * F && (n % F) != 1; t++) @(negedge clk);
    send(W'($urandom), 1'b0);
    for (int t = 0; t < 2 * F && (n % F) != 20 * BP + 2; t++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (F / 2) @(negedge clk);
    send(W'($urandom), 1'b0);
    repeat (3 * F) @(negedge clk);

    chk("pending_events", 64'(rd_q.size() + ur_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
